// File: rtl/dota_pkg.sv
// Shared types, default widths and latency helper for the OTA trim sequencer.
package dota_pkg;

  localparam int unsigned CODE_W_DEF   = 6;
  localparam int unsigned SETTLE_W_DEF = 4;
  localparam int unsigned VOTES_DEF    = 3;

  typedef enum logic [2:0] {
    IDLE,
    SETTLE,
    SAMPLE,
    DECIDE,
    FINISH
  } state_e;

  // Cycles from the edge that accepts start to the edge after which done is high.
  function automatic int unsigned search_latency(input int unsigned code_w,
                                                 input int unsigned settle,
                                                 input int unsigned votes);
    return code_w * (settle + votes + 1) + 1;
  endfunction

endpackage

// File: rtl/dota_sync2.sv
// Two-flop synchronizer with asynchronous active-low reset for analog return nets.
module dota_sync2 (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/dota_sar_trim_ctrl.sv
// SAR trim sequencer: steps a binary trim code, majority-votes the synchronized
// comparator return and reports the largest code for which it reads low.
module dota_sar_trim_ctrl
  import dota_pkg::*;
#(
  parameter int unsigned CODE_W   = CODE_W_DEF,
  parameter int unsigned SETTLE_W = SETTLE_W_DEF,
  parameter int unsigned VOTES    = VOTES_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                abort,
  input  logic [SETTLE_W-1:0] settle_cyc,
  input  logic                cmp_in,
  output logic                ota_en,
  output logic [CODE_W-1:0]   trim_code,
  output logic                busy,
  output logic                done,
  output logic [CODE_W-1:0]   result
);

  localparam int unsigned CNT_W = (VOTES > 1) ? $clog2(VOTES + 1) : 1;
  localparam int unsigned IDX_W = (CODE_W > 1) ? $clog2(CODE_W) : 1;

  state_e              state_q, state_d;
  logic [CODE_W-1:0]   trim_q, trim_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [SETTLE_W-1:0] settle_q, settle_d;
  logic [CNT_W-1:0]    ones_q, ones_d;
  logic [CNT_W-1:0]    vote_q, vote_d;
  logic [CODE_W-1:0]   result_q, result_d;
  logic                done_q, done_d;
  logic                cmp_s;

  dota_sync2 u_sync (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .d_i    (cmp_in),
    .q_o    (cmp_s)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      trim_q   <= '0;
      idx_q    <= '0;
      settle_q <= '0;
      ones_q   <= '0;
      vote_q   <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      trim_q   <= trim_d;
      idx_q    <= idx_d;
      settle_q <= settle_d;
      ones_q   <= ones_d;
      vote_q   <= vote_d;
      result_q <= result_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    trim_d   = trim_q;
    idx_d    = idx_q;
    settle_d = settle_q;
    ones_d   = ones_q;
    vote_d   = vote_q;
    result_d = result_q;
    done_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start && !abort) begin
          trim_d             = '0;
          trim_d[CODE_W-1]   = 1'b1;
          idx_d              = IDX_W'(CODE_W - 1);
          settle_d           = settle_cyc;
          ones_d             = '0;
          vote_d             = '0;
          state_d            = (settle_cyc == '0) ? SAMPLE : SETTLE;
        end
      end
      SETTLE: begin
        if (abort) begin
          state_d = IDLE;
        end else if (settle_q <= SETTLE_W'(1)) begin
          state_d = SAMPLE;
        end else begin
          settle_d = settle_q - SETTLE_W'(1);
        end
      end
      SAMPLE: begin
        if (abort) begin
          state_d = IDLE;
        end else begin
          ones_d = ones_q + CNT_W'(cmp_s);
          if (vote_q == CNT_W'(VOTES - 1)) begin
            vote_d  = '0;
            state_d = DECIDE;
          end else begin
            vote_d = vote_q + CNT_W'(1);
          end
        end
      end
      DECIDE: begin
        if (abort) begin
          state_d = IDLE;
        end else begin
          if (ones_q > CNT_W'(VOTES / 2)) begin
            trim_d[idx_q] = 1'b0;
          end
          if (idx_q != '0) begin
            trim_d[idx_q - IDX_W'(1)] = 1'b1;
            idx_d    = idx_q - IDX_W'(1);
            settle_d = settle_cyc;
            ones_d   = '0;
            state_d  = (settle_cyc == '0) ? SAMPLE : SETTLE;
          end else begin
            state_d = FINISH;
          end
        end
      end
      FINISH: begin
        state_d = IDLE;
        if (!abort) begin
          result_d = trim_q;
          done_d   = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy      = (state_q != IDLE);
  assign ota_en    = busy && (state_q != FINISH);
  assign trim_code = trim_q;
  assign done      = done_q;
  assign result    = result_q;

  // Latency tracker for the assertion; skipped when settle_cyc moved mid-search.
  int unsigned         lat_cnt_q;
  logic [SETTLE_W-1:0] lat_set_q;
  logic                lat_var_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lat_cnt_q <= 0;
      lat_set_q <= '0;
      lat_var_q <= 1'b0;
    end else if (state_q == IDLE) begin
      lat_cnt_q <= 0;
      lat_set_q <= settle_cyc;
      lat_var_q <= 1'b0;
    end else begin
      lat_cnt_q <= lat_cnt_q + 32'd1;
      if (state_q == DECIDE && settle_cyc != lat_set_q) begin
        lat_var_q <= 1'b1;
      end
    end
  end

  a_latency: assert property (@(posedge clk) disable iff (!rst_n)
    (state_q == FINISH && !lat_var_q) |->
      (lat_cnt_q + 32'd1 == search_latency(CODE_W, 32'(lat_set_q), VOTES)));

endmodule

// File: doc/dota_sar_trim_ctrl.md
Name: dota_sar_trim_ctrl

Overview:
Sequencer for the gate-level digital OTA/comparator macro. It enables the macro and steps a binary trim code that drives an external R-2R/offset DAC through the dedicated outputs. It reads the macro's comparison output back asynchronously, majority-votes it, and runs a successive-approximation search. The result is the largest trim code for which the comparator reads low. It sits between the top-level pin wrapper and the analog OTA cell.

Parameters:
CODE_W, 6, trim code width in bits (search depth).
SETTLE_W, 4, width of the programmable settle counter.
VOTES, 3, samples per decision; must be odd, at least 1.

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
start  input  1  one-cycle request to begin a search; accepted only in IDLE
abort  input  1  abandon search; return to IDLE
settle_cyc  input  SETTLE_W  wait cycles after each trim code change
cmp_in  input  1  OTA comparison output, asynchronous to clk
ota_en  output  1  enable for the OTA macro; high while busy
trim_code  output  CODE_W  live trim code driven to the DAC
busy  output  1  high in any state other than IDLE
done  output  1  one-cycle pulse when result is updated
result  output  CODE_W  last completed search result, held until next done

Behaviour:
- Reset
  - Clock is clk. Reset is rst_n, asynchronous assert, active-low.
  - All outputs go to 0, state goes to IDLE, and the synchronizer flops clear.
  - Reset mid-search drops everything immediately. No done pulse is generated and result is cleared to 0.
- Synchronizer
  - cmp_in passes through a 2-flop synchronizer; cmp_s is the second flop.
  - Only cmp_s is ever used.
  - With settle_cyc < 2, a decision may see the previous code. This is allowed; the bench must not flag it.
- FSM states: IDLE, SETTLE, SAMPLE, DECIDE, FINISH.
- IDLE
  - On start: load trim_code = 1 << (CODE_W-1), bit_idx = CODE_W-1, settle counter = settle_cyc.
  - Set ota_en = 1 and go to SETTLE.
- SETTLE
  - Count down; stay exactly settle_cyc cycles. A value of 0 goes straight to SAMPLE.
  - settle_cyc is captured at every code change, not held constant for the whole search.
- SAMPLE
  - Exactly VOTES cycles; ones_cnt accumulates cmp_s.
- DECIDE (1 cycle)
  - hi = (ones_cnt > VOTES/2).
  - If hi, clear trim_code[bit_idx].
  - If bit_idx > 0: set trim_code[bit_idx-1], decrement bit_idx, reload the settle counter, clear ones_cnt, go to SETTLE.
  - Otherwise go to FINISH.
- FINISH (1 cycle)
  - result = trim_code, done = 1, ota_en = 0, trim_code holds. Next state is IDLE.
- Latency
  - With start sampled at edge k, done is high in the cycle after edge k + CODE_W*(settle_cyc+VOTES+1) + 1.
- start handling
  - start while busy is ignored; it is neither queued nor restarts the search.
  - start and abort together in IDLE: abort wins and start is dropped.
- abort
  - In any non-IDLE state, the next edge goes to IDLE with ota_en = 0.
  - trim_code holds its last value, result is unchanged, and no done pulse is generated.
- Boundaries
  - cmp_s stuck 1 gives result 0.
  - cmp_s stuck 0 gives result 2^CODE_W - 1.
- Counters
  - ones_cnt is $clog2(VOTES+1) bits.
  - bit_idx is $clog2(CODE_W) bits and never underflows.

Decomposition:
- Shared package dota_pkg holds:
  - the state enum (IDLE..FINISH)
  - default widths (CODE_W, SETTLE_W, VOTES)
  - a function computing expected search latency, used by RTL assertions and the bench.
- One natural sub-module: dota_sync2, the 2-flop synchronizer with async active-low reset. It is reusable for other analog-return nets.
- The FSM and datapath stay in the top module.

Test Plan:
- Nominal search
  - Stimulus: CODE_W=6, VOTES=3, settle_cyc=2; bench model cmp_in = (trim_code >= 37), pulse start.
  - Required: trim_code sequence 32,48,40,36,38,37; result = 36; done exactly 37 cycles after start; ota_en low after done.
- Rails
  - Stimulus: cmp_in tied 1, then cmp_in tied 0.
  - Required: result = 0, then result = 63; each done pulse is 1 cycle wide.
- Vote filtering
  - Stimulus: same as nominal, plus a single-cycle inverted glitch on cmp_s inside every SAMPLE window.
  - Required: result still 36.
- Abort
  - Stimulus: assert abort during the third SETTLE; concurrently pulse start while busy on an earlier run.
  - Required: busy drops next cycle; no done; result keeps its previous value; the ignored start causes no restart.
- Reset mid-run
  - Stimulus: rst_n low asynchronously between edges during SAMPLE.
  - Required: all outputs 0 immediately; after release, a fresh start yields correct result 36.
- Zero settle
  - Stimulus: settle_cyc=0 with a constant cmp_in.
  - Required: latency = 6*(0+3+1)+1 = 25 cycles; no assertion fires.
